// File: rtl/sram_1r1w_param.sv
// sram_1r1w_param: parametrised single-clock 1R1W memory (port 0 writes, port 1 reads).
// Features: byte-lane write mask, 1- or 2-cycle read latency, selectable
// read-during-write behaviour, and a zero-fill sweep after every reset.
// Optional build macro SRAM_PARITY_EN adds one even-parity bit per byte lane
// and the rd_perr flag. Without it, rd_perr is constant 0 and perr_inj0 is ignored.
module sram_1r1w_param #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      csb0,
    input  logic [ADDR_WIDTH-1:0]     addr0,
    input  logic [DATA_WIDTH-1:0]     din0,
    input  logic [DATA_WIDTH/8-1:0]   wmask0,
    input  logic                      perr_inj0,
    input  logic                      csb1,
    input  logic [ADDR_WIDTH-1:0]     addr1,
    output logic [DATA_WIDTH-1:0]     dout1,
    output logic                      dout1_valid,
    output logic                      rd_perr,
    output logic                      busy
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int LANES     = DATA_WIDTH / 8;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH <= 0) begin : g_bad_width
        $error("sram_1r1w_param: DATA_WIDTH must be a positive multiple of 8");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sram_1r1w_param: READ_LATENCY must be 1 or 2");
    end

    // Replace the lanes selected by mask in old_w with the lanes of new_w.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [LANES-1:0]      mask
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
    logic                  busy_q, busy_d;
    logic                  init_we, wr_en, rd_en;

    // State register: reset restarts the zero-fill sweep from address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            busy_q      <= busy_d;
        end
    end

    // Next state: sweep one address per cycle, leave INIT after the last one.
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        busy_d      = busy_q;
        if (state_q == ST_INIT) begin
            init_addr_d = init_addr_q + ADDR_WIDTH'(1);
            if (init_addr_q == {ADDR_WIDTH{1'b1}}) begin
                state_d = ST_READY;
                busy_d  = 1'b0;
            end
        end
    end

    // Output decode: ports are only honoured in READY and never on a reset edge.
    always_comb begin
        init_we = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        if (!rst) begin
            init_we = (state_q == ST_INIT);
            wr_en   = (state_q == ST_READY) && !csb0;
            rd_en   = (state_q == ST_READY) && !csb1;
        end
    end

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic                  collide;
    logic [DATA_WIDTH-1:0] rd_old, rd_word;
    logic                  perr_calc;

    assign collide = wr_en && rd_en && (addr0 == addr1);

    // Storage array: sweep writes zeros, normal writes update enabled lanes only.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_q[init_addr_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask0[i]) mem_q[addr0][8*i +: 8] <= din0[8*i +: 8];
            end
        end
    end

    // Read word: on a same-address collision, write-first forwards the merged word.
    always_comb begin
        rd_old  = mem_q[addr1];
        rd_word = rd_old;
        if (WRITE_FIRST != 0 && collide) rd_word = merge_lanes(rd_old, din0, wmask0);
    end

`ifdef SRAM_PARITY_EN
    // Even parity per byte lane.
    function automatic logic [LANES-1:0] lane_parity(input logic [DATA_WIDTH-1:0] w);
        logic [LANES-1:0] p;
        for (int i = 0; i < LANES; i++) p[i] = ^w[8*i +: 8];
        return p;
    endfunction

    logic [LANES-1:0] par_q [RAM_DEPTH];
    logic [LANES-1:0] par_wr, par_rd;

    assign par_wr = lane_parity(din0) ^ {LANES{perr_inj0}};

    // Parity array tracks the data array lane by lane; the sweep stores consistent zeros.
    always_ff @(posedge clk) begin
        if (init_we) begin
            par_q[init_addr_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask0[i]) par_q[addr0][i] <= par_wr[i];
            end
        end
    end

    // Parity check on the word actually returned, including forwarded lanes.
    always_comb begin
        par_rd = par_q[addr1];
        if (WRITE_FIRST != 0 && collide) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask0[i]) par_rd[i] = par_wr[i];
            end
        end
        perr_calc = |(lane_parity(rd_word) ^ par_rd);
    end
`else
    logic unused_perr_inj;
    assign unused_perr_inj = perr_inj0;
    assign perr_calc       = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] out_data_d;
    logic                  out_vld_d, out_perr_d;

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] data_p0_q;
        logic                  vld_p0_q, perr_p0_q;

        // Stage 0 control: captured at the accept edge, flushed by reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p0_q  <= 1'b0;
                perr_p0_q <= 1'b0;
            end else begin
                vld_p0_q  <= rd_en;
                perr_p0_q <= rd_en & perr_calc;
            end
        end

        // Stage 0 data: snapshot at accept, so later writes cannot disturb it.
        always_ff @(posedge clk) begin
            if (rd_en) data_p0_q <= rd_word;
        end

        assign out_data_d = data_p0_q;
        assign out_vld_d  = vld_p0_q;
        assign out_perr_d = perr_p0_q;
    end else begin : g_lat1
        assign out_data_d = rd_word;
        assign out_vld_d  = rd_en;
        assign out_perr_d = rd_en & perr_calc;
    end

    logic [DATA_WIDTH-1:0] dout1_q;
    logic                  dout1_valid_q, rd_perr_q;

    // Output stage: dout1 holds its value between completed reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout1_q       <= '0;
            dout1_valid_q <= 1'b0;
            rd_perr_q     <= 1'b0;
        end else begin
            dout1_valid_q <= out_vld_d;
            rd_perr_q     <= out_perr_d;
            if (out_vld_d) dout1_q <= out_data_d;
        end
    end

    assign dout1       = dout1_q;
    assign dout1_valid = dout1_valid_q;
    assign rd_perr     = rd_perr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_sram_1r1w_param.sv
// Directed testbench for sram_1r1w_param (32x32 geometry).
// READ_LATENCY / WRITE_FIRST below may be changed to exercise the other builds.
module tb_sram_1r1w_param;

    localparam int LAT = 1;
    localparam int WF  = 1;
`ifdef SRAM_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        csb0;
    logic [4:0]  addr0;
    logic [31:0] din0;
    logic [3:0]  wmask0;
    logic        perr_inj0;
    logic        csb1;
    logic [4:0]  addr1;
    logic [31:0] dout1;
    logic        dout1_valid;
    logic        rd_perr;
    logic        busy;

    sram_1r1w_param #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (5),
        .READ_LATENCY(LAT),
        .WRITE_FIRST (WF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .csb0       (csb0),
        .addr0      (addr0),
        .din0       (din0),
        .wmask0     (wmask0),
        .perr_inj0  (perr_inj0),
        .csb1       (csb1),
        .addr1      (addr1),
        .dout1      (dout1),
        .dout1_valid(dout1_valid),
        .rd_perr    (rd_perr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_mem [32];
    logic [31:0] rd_d;
    logic        rd_v, rd_p;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m, input logic inj);
        csb0 = 1'b0; addr0 = a; din0 = d; wmask0 = m; perr_inj0 = inj;
        tick();
        csb0 = 1'b1; perr_inj0 = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d, output logic v, output logic pe);
        csb1 = 1'b0; addr1 = a;
        tick();
        csb1 = 1'b1;
        chk("rd_first_cycle_vld", 32'(dout1_valid), (LAT == 1) ? 32'd1 : 32'd0);
        if (LAT == 2) tick();
        d = dout1; v = dout1_valid; pe = rd_perr;
    endtask

    // Counts busy cycles from the first sample after the last reset edge.
    task automatic wait_init();
        int   n;
        logic saw;
        n = 0; saw = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            if (dout1_valid !== 1'b0) saw = 1'b1;
            n++;
            tick();
        end
        chk("init_busy_cycles", 32'(n), 32'd32);
        chk("init_no_valid", 32'(saw), 32'd0);
    endtask

    task automatic stream_chk(input string tag);
        int j;
        for (int c = 0; c < 32 + LAT; c++) begin
            if (c < 32) begin
                csb1 = 1'b0; addr1 = 5'(c);
            end else begin
                csb1 = 1'b1;
            end
            tick();
            j = c - (LAT - 1);
            if (j >= 0 && j < 32) begin
                chk($sformatf("%s_vld%0d", tag, j), 32'(dout1_valid), 32'd1);
                chk($sformatf("%s_data%0d", tag, j), dout1, exp_mem[j]);
                chk($sformatf("%s_perr%0d", tag, j), 32'(rd_perr), 32'd0);
            end else begin
                chk($sformatf("%s_idle%0d", tag, c), 32'(dout1_valid), 32'd0);
            end
        end
        csb1 = 1'b1;
    endtask

    initial begin
        rst = 1'b1; csb0 = 1'b1; csb1 = 1'b1; addr0 = '0; addr1 = '0;
        din0 = '0; wmask0 = '0; perr_inj0 = 1'b0;
        tick();
        tick();
        chk("rst_dout", dout1, 32'h0);
        chk("rst_vld", 32'(dout1_valid), 32'd0);
        chk("rst_perr", 32'(rd_perr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        // init sweep with a read request held active
        rst = 1'b0; csb1 = 1'b0; addr1 = 5'd5;
        wait_init();
        csb1 = 1'b1;
        chk("post_init_vld", 32'(dout1_valid), 32'd0);
        for (int k = 0; k < 32; k++) exp_mem[k] = 32'h0;
        stream_chk("init_zero");

        // masked writes
        wr(5'd3, 32'hDEADBEEF, 4'b1111, 1'b0);
        wr(5'd3, 32'h11223344, 4'b0101, 1'b0);
        rd(5'd3, rd_d, rd_v, rd_p);
        chk("mask_vld", 32'(rd_v), 32'd1);
        chk("mask_data", rd_d, 32'hDE22BE44);
        tick();
        chk("hold_vld", 32'(dout1_valid), 32'd0);
        chk("hold_data", dout1, 32'hDE22BE44);
        wr(5'd3, 32'hFFFFFFFF, 4'b0000, 1'b0);
        rd(5'd3, rd_d, rd_v, rd_p);
        chk("mask0_noop", rd_d, 32'hDE22BE44);

        // full-word collision
        wr(5'd7, 32'hAAAAAAAA, 4'b1111, 1'b0);
        csb0 = 1'b0; addr0 = 5'd7; din0 = 32'h55555555; wmask0 = 4'b1111;
        csb1 = 1'b0; addr1 = 5'd7;
        tick();
        csb0 = 1'b1; csb1 = 1'b1;
        if (LAT == 2) tick();
        chk("coll_vld", 32'(dout1_valid), 32'd1);
        chk("coll_data", dout1, (WF != 0) ? 32'h55555555 : 32'hAAAAAAAA);
        rd(5'd7, rd_d, rd_v, rd_p);
        chk("coll_after", rd_d, 32'h55555555);

        // partial-mask collision
        csb0 = 1'b0; addr0 = 5'd7; din0 = 32'hAAAAAAAA; wmask0 = 4'b0011;
        csb1 = 1'b0; addr1 = 5'd7;
        tick();
        csb0 = 1'b1; csb1 = 1'b1;
        if (LAT == 2) tick();
        chk("pcoll_data", dout1, (WF != 0) ? 32'h5555AAAA : 32'h55555555);
        rd(5'd7, rd_d, rd_v, rd_p);
        chk("pcoll_after", rd_d, 32'h5555AAAA);

        // streaming
        for (int k = 0; k < 32; k++) begin
            wr(5'(k), 32'(k) * 32'h01010101, 4'b1111, 1'b0);
            exp_mem[k] = 32'(k) * 32'h01010101;
        end
        stream_chk("stream");

        // write to an address whose read is already accepted
        csb1 = 1'b0; addr1 = 5'd9;
        tick();
        csb1 = 1'b1;
        csb0 = 1'b0; addr0 = 5'd9; din0 = 32'hCAFEF00D; wmask0 = 4'b1111;
        tick();
        csb0 = 1'b1;
        chk("inflight_vld", 32'(dout1_valid), (LAT == 2) ? 32'd1 : 32'd0);
        chk("inflight_data", dout1, 32'h09090909);
        rd(5'd9, rd_d, rd_v, rd_p);
        chk("inflight_after", rd_d, 32'hCAFEF00D);

        // parity injection and repair
        wr(5'd1, 32'h000000FF, 4'b0001, 1'b1);
        rd(5'd1, rd_d, rd_v, rd_p);
        chk("par_inj_data", rd_d, 32'h010101FF);
        chk("par_inj_perr", 32'(rd_p), 32'(PAR_EN));
        wr(5'd1, 32'h000000FF, 4'b0001, 1'b0);
        rd(5'd1, rd_d, rd_v, rd_p);
        chk("par_ok_perr", 32'(rd_p), 32'd0);
        chk("par_ok_vld", 32'(rd_v), 32'd1);

        // reset on the edge after a read is accepted
        csb1 = 1'b0; addr1 = 5'd9;
        tick();
        csb1 = 1'b1; rst = 1'b1;
        tick();
        chk("midrst_vld", 32'(dout1_valid), 32'd0);
        chk("midrst_dout", dout1, 32'h0);
        chk("midrst_busy", 32'(busy), 32'd1);
        chk("midrst_perr", 32'(rd_perr), 32'd0);
        rst = 1'b0; csb1 = 1'b0; addr1 = 5'd9;
        wait_init();
        csb1 = 1'b1;
        for (int k = 0; k < 32; k++) exp_mem[k] = 32'h0;
        stream_chk("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_1r1w_param.md
Name: sram_1r1w_param

Overview:
Parametrised, synthesizable single-clock 1R1W memory. It is the successor to the fixed 32x32 OpenRAM macro model. It adds configurable width and depth, byte-lane write masking, selectable read latency, defined read-during-write collision behaviour, and a post-reset zero-initialisation sweep. It sits between the ASCON datapath and its state/key/nonce storage, and holds the same port-0-write / port-1-read split as the macro.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8 (elaboration error otherwise)
ADDR_WIDTH, 5, address bits; RAM_DEPTH = 1 << ADDR_WIDTH
READ_LATENCY, 1, cycles from read-accept edge to dout1 valid; legal values 1 or 2 (elaboration error otherwise)
WRITE_FIRST, 1, same-address same-edge collision: 1 = read returns new data, 0 = read returns old data

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous, active-high reset
csb0  input  1  active-low write enable, port 0
addr0  input  ADDR_WIDTH  write address
din0  input  DATA_WIDTH  write data
wmask0  input  DATA_WIDTH/8  byte-lane write mask; bit i covers din0[8i+7:8i]
perr_inj0  input  1  test hook: invert stored parity of written lanes (used only with SRAM_PARITY_EN)
csb1  input  1  active-low read enable, port 1
addr1  input  ADDR_WIDTH  read address
dout1  output  DATA_WIDTH  read data, registered
dout1_valid  output  1  one-cycle pulse marking dout1 as fresh
rd_perr  output  1  parity error flag, aligned with dout1_valid
busy  output  1  high while the init sweep runs; both ports are ignored while busy

Behaviour:
- One clock domain. Reset is synchronous and active-high. Sampled on posedge clk when rst=1:
  - state=INIT, init_addr=0
  - dout1=0, dout1_valid=0, rd_perr=0, busy=1
  - the read pipeline is flushed.
- FSM INIT:
  - Each edge with rst=0 writes all-zero data (and zero parity) to mem[init_addr], then init_addr increments.
  - The edge that writes RAM_DEPTH-1 moves the FSM to READY and registers busy=0.
  - busy is therefore high for exactly RAM_DEPTH cycles after rst is released.
  - csb0 and csb1 are ignored in INIT; dout1_valid stays 0.
- FSM READY:
  - READY persists until rst.
  - Write: on an edge with csb0=0, every lane i with wmask0[i]=1 takes din0 into mem[addr0]. Unmasked lanes are unchanged. wmask0=0 is a legal no-op.
  - Read: on an edge T with csb1=0, addr1 is accepted.
    - READ_LATENCY=1: dout1 and dout1_valid=1 are registered at edge T, visible in cycle T+1.
    - READ_LATENCY=2: they are registered at edge T+1.
  - Back-to-back reads give one result per cycle. There are no stalls and no backpressure.
  - dout1 holds its last value when no read completes. dout1_valid is 1 only on completion cycles.
- Collision: csb0=0, csb1=0 and addr0==addr1 on the same edge.
  - WRITE_FIRST=1: the read returns the merged word (masked lanes from din0, other lanes old).
  - WRITE_FIRST=0: the read returns the pre-write word.
  - The write is always performed.
  - A write to an address already accepted by an in-flight read (READ_LATENCY=2) does not alter that read's data.
- Reset mid-operation: in-flight reads are discarded (no valid pulse), the sweep restarts from address 0, and prior contents are zeroed.
- Address wrap: addresses are modulo RAM_DEPTH by construction; there is no out-of-range case.

Optional Feature:
Macro SRAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane, computed from din0 on write. The bit is inverted for written lanes when perr_inj0=1.
  - On read, parity is recomputed per lane.
  - rd_perr=1, registered with the same latency as dout1_valid, if any lane mismatches. rd_perr is 0 whenever dout1_valid=0.
  - The init sweep writes consistent parity.
- Undefined:
  - No parity storage.
  - rd_perr is tied to 0 and perr_inj0 is ignored.
  - All ports remain present in both builds.

Test Plan:
1. Reset/init (defaults): rst high 2 cycles, then low -> busy=1 for exactly 32 cycles, then 0. A read of every address returns 0. dout1_valid stays 0 while busy, even if csb1=0.
2. Masked write: write 0xDEADBEEF to addr 3 with wmask0=4'b1111, then 0x11223344 with wmask0=4'b0101 -> read addr 3 returns 0xDE22BE44. Valid appears 1 cycle after the accept edge (READ_LATENCY=1), or 2 cycles after (READ_LATENCY=2).
3. Collision: mem[7]=0xAAAAAAAA; same edge write 0x55555555 (mask 4'b1111) and read addr 7 -> dout1=0x55555555 with WRITE_FIRST=1, 0xAAAAAAAA with WRITE_FIRST=0. A following read returns 0x55555555 in both cases.
4. Streaming: reads of addrs 0..31 on consecutive edges after writing addr k = k*0x01010101 -> 32 consecutive dout1_valid pulses, data in order, no gaps, at both latencies.
5. Reset mid-read: READ_LATENCY=2, read accepted, rst asserted next edge -> no dout1_valid pulse, dout1=0, busy=1, and all memory reads 0 after the sweep.
6. Parity (SRAM_PARITY_EN): write 0x000000FF to addr 1 with perr_inj0=1, mask 4'b0001 -> read gives rd_perr=1 with dout1_valid. Rewrite with perr_inj0=0 -> rd_perr=0. Without the macro, rd_perr is always 0.
